frame_serializer: RTL
=====================

FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 Parameters: none; frame width fixed at 12 bits, the frame generator's output width.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-004 baud_tick  input  1  one-clk-wide pulse marking each UART bit boundary.
REQ-005 send  input  1  start request; level-sampled, honoured only in IDLE.
REQ-006 frame_in  input  12  frame from frame generator; start bit at index len-1, last stop bit at index 0, unused MSBs zero.
REQ-007 parity_type  input  2  00/11 = no parity bit, 01/10 = parity bit present.
REQ-008 stop_bits  input  1  0 = 1 stop bit, 1 = 2 stop bits.
REQ-009 data_length  input  1  0 = 7 data bits, 1 = 8 data bits.
REQ-010 tx_out  output  1  serial line; idle-high.
REQ-011 busy  output  1  high while a frame is held or shifting.
REQ-012 done  output  1  one-clk pulse at frame completion.

Function
REQ-013 Frame length len = 1 + (data_length ? 8 : 7) + (parity_type in {01,10} ? 1 : 0) + (stop_bits ? 2 : 1); range 9..12; 4-bit unsigned.
REQ-014 States: IDLE, ARMED, SHIFT; all outputs registered.
REQ-015 IDLE: tx_out=1, busy=0; send=1 at an edge -> latch frame_in and len into shadow registers, bit index idx = len-1, go ARMED, busy=1 next cycle.
REQ-016 Config and frame_in are sampled only at capture; changes during ARMED/SHIFT have no effect on the frame in flight.
REQ-017 ARMED: tx_out held 1; on the next baud_tick -> tx_out = shadow[idx] (start bit), go SHIFT; a baud_tick coincident with capture does not count.
REQ-018 SHIFT: on each baud_tick with idx > 0 -> idx decrements, tx_out = shadow[idx-1]; tx_out constant between ticks.
REQ-019 SHIFT: on baud_tick with idx = 0 (last stop bit held one full tick period) -> tx_out=1, busy=0, done=1 for exactly one cycle, go IDLE.
REQ-020 Every bit, including each stop bit, occupies exactly one baud_tick interval; frame spans len intervals from first to terminating tick.
REQ-021 send while busy=1 ignored, not queued.
REQ-022 send=1 in the cycle done=1 is accepted (state is IDLE); back-to-back frames separated by the ARMED wait only.
REQ-023 send held high continuously -> a new frame is captured each time IDLE is entered.
REQ-024 baud_tick with no send in IDLE has no effect.
REQ-025 Bits of frame_in above index len-1 are never driven onto tx_out.

Reset
REQ-026 rst=0 at an edge, in any state -> next cycle: state IDLE, tx_out=1, busy=0, done=0, idx=0, shadow registers cleared; frame in flight abandoned.
REQ-027 rst=0 has priority over send and baud_tick in the same cycle; no capture occurs while rst=0.
REQ-028 First send honoured is the first edge with rst=1 and send=1.

Verification
REQ-029 8 data, no parity, 1 stop, frame_in=12'h14B (data A5), send pulse -> after first tick tx_out per tick: 0,1,0,1,0,0,1,0,1,1; done on 10th tick; busy high throughout.
REQ-030 parity_type=01, 8 data, 2 stop, frame_in=12'h52B ({0,A5,0,1,1}) -> 12 bits 0,1,0,1,0,0,1,0,1,0,1,1; done on 12th tick.
REQ-031 7 data, parity_type=00, 1 stop, frame_in=12'h0AB ({0,1010101,1}) -> 9 bits 0,1,0,1,0,1,0,1,1; done on 9th tick; frame_in bits 11:9 never appear.
REQ-032 send re-pulsed mid-frame and frame_in/config changed mid-frame -> original bit sequence unaltered; second request dropped; send in done cycle -> new frame starts at following tick.
REQ-033 rst=0 asserted during data bit 4 -> next cycle tx_out=1, busy=0, done=0; no done pulse; subsequent send transmits a complete correct frame.
REQ-034 send and baud_tick in same cycle in IDLE -> tx_out stays 1 until the next tick, then start bit 0.

Source files
------------

// File: rtl/frame_serializer.sv
// Serializes a pre-built 12-bit UART frame MSB-first (start bit at index len-1)
// one bit per baud_tick; all outputs registered.
module frame_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        baud_tick,
    input  logic        send,
    input  logic [11:0] frame_in,
    input  logic [1:0]  parity_type,
    input  logic        stop_bits,
    input  logic        data_length,
    output logic        tx_out,
    output logic        busy,
    output logic        done,
    output logic [1:0]  state_dbg
);

    // Handshake: a request is send=1 at a rising edge while busy=0; it is
    // accepted there (busy rises next cycle). Requests while busy=1 are dropped.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [11:0] shadow;
    logic [11:0] shadow_next;
    logic [3:0]  idx;
    logic [3:0]  idx_next;
    logic        tx_next;
    logic        busy_next;
    logic        done_next;
    logic [3:0]  frame_len;
    logic        parity_on;

    assign parity_on = parity_type[1] ^ parity_type[0];
    assign frame_len = 4'd1 + (data_length ? 4'd8 : 4'd7) + {3'b000, parity_on}
                     + (stop_bits ? 4'd2 : 4'd1);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            shadow <= 12'h000;
            idx    <= 4'd0;
            tx_out <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            shadow <= shadow_next;
            idx    <= idx_next;
            tx_out <= tx_next;
            busy   <= busy_next;
            done   <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (send) state_next = ARMED;
            ARMED:   if (baud_tick) state_next = SHIFT;
            SHIFT:   if (baud_tick && (idx == 4'd0)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        shadow_next = shadow;
        idx_next    = idx;
        tx_next     = tx_out;
        busy_next   = busy;
        done_next   = 1'b0;
        case (state)
            IDLE: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
                if (send) begin
                    shadow_next = frame_in;
                    idx_next    = frame_len - 4'd1;
                    busy_next   = 1'b1;
                end
            end
            ARMED: begin
                busy_next = 1'b1;
                if (baud_tick) tx_next = shadow[idx];
            end
            SHIFT: begin
                busy_next = 1'b1;
                if (baud_tick) begin
                    if (idx != 4'd0) begin
                        idx_next = idx - 4'd1;
                        tx_next  = shadow[idx - 4'd1];
                    end else begin
                        // Last stop bit has been held a full period: release the line.
                        tx_next   = 1'b1;
                        busy_next = 1'b0;
                        done_next = 1'b1;
                    end
                end
            end
            default: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
            end
        endcase
    end

endmodule
